// File: rtl/word_unshift.sv
// Rotate-left word transform that undoes a logical rotate-right, behind a valid/ready handshake.
// Default build rotates one bit per cycle; define WORD_UNSHIFT_BARREL_EN for a single-cycle barrel rotator.
module word_unshift #(
    parameter int W = 8,
    localparam int AW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  __in0,
    input  logic [AW-1:0] __in_amt,
    input  logic          __in_valid,
    output logic          __in_ready,
    output logic [W-1:0]  __out0,
    output logic          __out_valid,
    input  logic          __out_ready,
    output logic          __busy
);

`ifdef WORD_UNSHIFT_BARREL_EN
    typedef enum logic {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t state, state_next;
    logic [W-1:0] out_q;
    logic         accept;
    logic         release_out;

    // Decoded from state directly so the handshake terms never loop through the output logic.
    assign accept      = __in_valid && (state == IDLE);
    assign release_out = __out_ready && (state == DONE);
    assign __out0      = out_q;

`ifdef WORD_UNSHIFT_BARREL_EN

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [AW-1:0] amt);
        logic [2*W-1:0] dbl;
        dbl = {x, x} << amt;
        return dbl[2*W-1:W];
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next  = state;
        __in_ready  = 1'b0;
        __out_valid = 1'b0;
        __busy      = 1'b0;
        case (state)
            IDLE: begin
                __in_ready = 1'b1;
                if (accept) state_next = DONE;
            end
            DONE: begin
                __out_valid = 1'b1;
                if (release_out) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            out_q <= '0;
        end else begin
            state <= state_next;
            if (accept) out_q <= rotl(__in0, __in_amt);
        end
    end

`else

    logic [W-1:0]  data_q;
    logic [AW-1:0] count_q;
    logic [W-1:0]  data_rot1;

    assign data_rot1 = {data_q[W-2:0], data_q[W-1]};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next  = state;
        __in_ready  = 1'b0;
        __out_valid = 1'b0;
        __busy      = 1'b0;
        case (state)
            IDLE: begin
                __in_ready = 1'b1;
                if (accept) state_next = (__in_amt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                __busy = 1'b1;
                if (count_q == AW'(1)) state_next = DONE;
            end
            DONE: begin
                __out_valid = 1'b1;
                if (release_out) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The result register only changes on entry to DONE, so __out0 never shows partial rotations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q  <= __in0;
                        count_q <= __in_amt;
                        if (__in_amt == '0) out_q <= __in0;
                    end
                end
                SHIFT: begin
                    data_q  <= data_rot1;
                    count_q <= count_q - AW'(1);
                    if (count_q == AW'(1)) out_q <= data_rot1;
                end
                default: ;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_word_unshift.sv
// Self-checking bench for word_unshift: directed scenarios, full loopback sweep and random traffic
// compared against arithmetic rotate reference functions.
module tb_word_unshift;

    localparam int W = 8;

`ifdef WORD_UNSHIFT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in0 = '0;
    logic [2:0]   in_amt = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    word_unshift #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .__in0      (in0),
        .__in_amt   (in_amt),
        .__in_valid (in_valid),
        .__in_ready (in_ready),
        .__out0     (out0),
        .__out_valid(out_valid),
        .__out_ready(out_ready),
        .__busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl_ref(input logic [7:0] w, input int a);
        int v;
        v = (int'(w) << a) | (int'(w) >> (8 - a));
        return v[7:0];
    endfunction

    function automatic logic [7:0] rotr_ref(input logic [7:0] w, input int a);
        int v;
        v = (int'(w) >> a) | (int'(w) << (8 - a));
        return v[7:0];
    endfunction

    function automatic int exp_latency(input int a);
        if (BARREL || a == 0) return 1;
        return a + 1;
    endfunction

    // Waits (bounded) for out_valid, counting cycles and busy cycles since the input handshake.
    task automatic wait_result(output int lat, output int busy_n, output bit ready_low);
        lat = 0;
        busy_n = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (in_ready) ready_low = 1'b0;
        end while (!out_valid && lat < 40);
    endtask

    // One full transaction starting at a negedge: input handshake, result, hold, output handshake.
    task automatic txn(input string tag, input logic [7:0] w, input int a,
                       input logic [7:0] exp, input int hold);
        int lat, busy_n;
        bit ready_low, stable;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        in0 = w;
        in_amt = 3'(a);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(lat, busy_n, ready_low);
        check({tag, "_latency"}, lat, exp_latency(a));
        check({tag, "_busy_cycles"}, busy_n, BARREL ? 0 : a);
        check({tag, "_data"}, out0, exp);
        stable = ready_low;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out0 !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check({tag, "_hold_stable"}, stable, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int lat, busy_n;
        bit ready_low, seen;
        logic [7:0] w;
        int a;

        // Reset state
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out0", out0, 0);
        check("reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        txn("basic", 8'h20, 3, 8'h01, 0);
        txn("zero_amt", 8'h5A, 0, 8'h5A, 0);

        // Asynchronous reset in the middle of a rotation discards the word.
        in0 = 8'hA5;
        in_amt = 3'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out0", out0, 0);
        check("midreset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midreset_no_output", seen, 0);

        txn("backpressure", 8'h81, 7, 8'hC0, 5);

        // Input offered while busy is ignored until the block returns to IDLE.
        in0 = 8'h01;
        in_amt = 3'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in0 = 8'hFF;
        in_amt = 3'd3;
        wait_result(lat, busy_n, ready_low);
        check("ignored_first_data", out0, 8'h04);
        check("ignored_first_latency", lat, exp_latency(2));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("ignored_in_ready_after", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(lat, busy_n, ready_low);
        check("ignored_second_data", out0, 8'hFF);
        check("ignored_second_latency", lat, exp_latency(3));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);

        // Loopback: every word pre-rotated right, every amount, must come back unchanged.
        for (int wv = 0; wv < 256; wv++) begin
            for (int av = 0; av < 8; av++) begin
                txn("loopback", rotr_ref(8'(wv), av), av, 8'(wv), $urandom_range(0, 1));
            end
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 200; i++) begin
            w = 8'($urandom);
            a = $urandom_range(0, 7);
            txn("random", w, a, rotl_ref(w, a), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
